// File: rtl/store_buffer_drain.sv
// Post-commit store buffer: a circular FIFO of committed stores that is
// drained oldest-first to data memory over a req/ack write handshake, and
// that forwards the youngest matching pending store to younger loads.
module store_buffer_drain #(
    parameter int SB_SIZE = 5,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [SB_SIZE:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int               DEPTH     = 1 << SB_SIZE;
    localparam logic [SB_SIZE:0] DEPTH_CNT = (SB_SIZE + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [SB_SIZE-1:0] head_q, head_d;
    logic [SB_SIZE-1:0] tail_q, tail_d;
    logic [SB_SIZE:0]   count_q, count_d;
    logic [0:0]         state_q, state_d;

    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    logic               push_fire;
    logic               pop_fire;

    // Status flags come from the registered count only, so a same-cycle pop
    // never opens room for a push into a full buffer.
    assign full       = (count_q == DEPTH_CNT);
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign count      = count_q;

    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = (state_q == ST_REQ) && mem_ack;

    // Head entry is presented only while requesting; otherwise the bus reads 0.
    assign mem_req    = (state_q == ST_REQ);
    assign mem_addr   = mem_req ? addr_mem[head_q] : '0;
    assign mem_data   = mem_req ? data_mem[head_q] : '0;

    // Next-state: pointers, occupancy and the two-state drain FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;
        if (push_fire) tail_d = tail_q + 1'b1;
        if (pop_fire)  head_d = head_q + 1'b1;
        count_d = count_q + (SB_SIZE + 1)'(push_fire) - (SB_SIZE + 1)'(pop_fire);
        case (state_q)
            ST_IDLE: if (count_q != '0) state_d = ST_REQ;
            ST_REQ:  if (mem_ack && count_d == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers; reset wins over push and ack.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Entry storage write at tail on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is not reset; occupancy (count/head) decides which entries are meaningful.
        if (push_fire && !reset) begin
            addr_mem[tail_q] <= push_addr;
            data_mem[tail_q] <= push_data;
        end
    end

    // Forwarding lookup: walk occupied entries oldest to youngest, last match wins.
    always_comb begin
        logic [SB_SIZE-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (ld_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + SB_SIZE'(k);
                if (((SB_SIZE + 1)'(k) < count_q) && (addr_mem[idx] == ld_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_drain.sv
// Self-checking bench for store_buffer_drain: a table of per-cycle vectors
// for the basic handshake and forwarding, plus hand-written sequences for
// back-to-back drain, full/wrap, push+pop at count 1 and mid-transfer reset.
module tb_store_buffer_drain;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_addr;
    logic [15:0] push_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [5:0]  count;
    logic        empty;
    logic        full;

    int tests_run = 0;
    int tests_failed = 0;

    store_buffer_drain #(.SB_SIZE(5), .ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [15:0] pa;
        logic [15:0] pd;
        logic        ack;
        logic        lv;
        logic [15:0] la;
        logic [5:0]  cnt;
        logic        req;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic        hit;
        logic [15:0] fdata;
        logic        emp;
        logic        ful;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(logic pv, logic [15:0] pa, logic [15:0] pd, logic ack,
                                logic lv, logic [15:0] la, logic [5:0] cnt, logic req,
                                logic [15:0] maddr, logic [15:0] mdata, logic hit,
                                logic [15:0] fdata, logic emp, logic ful, logic rdy);
        vec_t v;
        v.rst = 1'b0; v.pv = pv; v.pa = pa; v.pd = pd; v.ack = ack; v.lv = lv; v.la = la;
        v.cnt = cnt; v.req = req; v.maddr = maddr; v.mdata = mdata; v.hit = hit;
        v.fdata = fdata; v.emp = emp; v.ful = ful; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic rst, input logic pv, input logic [15:0] pa,
                         input logic [15:0] pd, input logic ack, input logic lv,
                         input logic [15:0] la);
        @(negedge clk);
        reset = rst; push_valid = pv; push_addr = pa; push_data = pd;
        mem_ack = ack; ld_valid = lv; ld_addr = la;
        #1;
    endtask

    function automatic logic [63:0] outs_now();
        return {5'd0, count, mem_req, mem_addr, mem_data, fwd_hit, fwd_data, empty, full, push_ready};
    endfunction

    function automatic logic [63:0] outs_exp(vec_t v);
        return {5'd0, v.cnt, v.req, v.maddr, v.mdata, v.hit, v.fdata, v.emp, v.ful, v.rdy};
    endfunction

    vec_t vecs[16];
    logic [31:0] sb_q[$];

    initial begin
        // Vectors: inputs for this cycle, and outputs seen before the clock edge.
        vecs[0]  = mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[1]  = mk(1, 16'h0010, 16'hAAAA, 0, 1, 16'h0010, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[2]  = mk(0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 6'd1, 0, 16'h0000, 16'h0000, 1, 16'hAAAA, 0, 0, 1);
        vecs[3]  = mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6'd1, 1, 16'h0010, 16'hAAAA, 0, 16'h0000, 0, 0, 1);
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = mk(0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 6'd1, 1, 16'h0010, 16'hAAAA, 0, 16'h0000, 0, 0, 1);
        vecs[7]  = mk(0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[8]  = mk(1, 16'h0020, 16'h1111, 0, 0, 16'h0000, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[9]  = mk(1, 16'h0020, 16'h2222, 0, 1, 16'h0020, 6'd1, 0, 16'h0000, 16'h0000, 1, 16'h1111, 0, 0, 1);
        vecs[10] = mk(0, 16'h0000, 16'h0000, 0, 1, 16'h0020, 6'd2, 1, 16'h0020, 16'h1111, 1, 16'h2222, 0, 0, 1);
        vecs[11] = mk(0, 16'h0000, 16'h0000, 1, 1, 16'h0020, 6'd2, 1, 16'h0020, 16'h1111, 1, 16'h2222, 0, 0, 1);
        vecs[12] = mk(0, 16'h0000, 16'h0000, 1, 1, 16'h0020, 6'd1, 1, 16'h0020, 16'h2222, 1, 16'h2222, 0, 0, 1);
        vecs[13] = mk(0, 16'h0000, 16'h0000, 0, 1, 16'h0020, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[14] = mk(0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);
        vecs[15] = mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1);

        reset = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        mem_ack = 1'b0; ld_valid = 1'b0; ld_addr = '0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Table: reset state, single store handshake, forwarding, idle ack.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].ack, vecs[i].lv, vecs[i].la);
            check($sformatf("vec%0d", i), outs_now(), outs_exp(vecs[i]));
        end

        // Back-to-back drain of three stores with ack held high.
        drive(0, 1, 16'h0100, 16'hB000, 0, 0, 0);
        drive(0, 1, 16'h0101, 16'hB001, 0, 0, 0);
        drive(0, 1, 16'h0102, 16'hB002, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            check($sformatf("b2b_beat%0d", k), {31'd0, mem_req, mem_addr, mem_data},
                  {31'd0, 1'b1, 16'h0100 + 16'(k), 16'hB000 + 16'(k)});
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        check("b2b_idle", {62'd0, mem_req, empty}, {62'd0, 1'b0, 1'b1});

        // Fill to 32 entries with no ack.
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, 16'h0200 + 16'(k), 16'hC000 + 16'(k), 0, 0, 0);
            sb_q.push_back({16'h0200 + 16'(k), 16'hC000 + 16'(k)});
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("full_state", {56'd0, count, full, push_ready}, {56'd0, 6'd32, 1'b1, 1'b0});

        // 33rd push with simultaneous ack: pop happens, push is refused.
        drive(0, 1, 16'h0FFF, 16'hDEAD, 1, 0, 0);
        check("full_pop", {32'd0, mem_addr, mem_data}, {32'd0, sb_q[0]});
        void'(sb_q.pop_front());
        drive(0, 0, 0, 0, 0, 0, 0);
        check("after_refused", {56'd0, count, full, push_ready}, {56'd0, 6'd31, 1'b0, 1'b1});

        // Stream 40 pushes while draining: pointers wrap, order must hold.
        for (int k = 0; k < 40; k++) begin
            drive(0, 1, 16'h0300 + 16'(k), 16'hE000 + 16'(k), 1, 0, 0);
            check($sformatf("wrap_pop%0d", k), {31'd0, mem_req, mem_addr, mem_data},
                  {31'd0, 1'b1, sb_q[0]});
            void'(sb_q.pop_front());
            sb_q.push_back({16'h0300 + 16'(k), 16'hE000 + 16'(k)});
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("wrap_count", {58'd0, count}, {58'd0, 6'd31});

        // Drain the remainder; the loop is bounded by the model's occupancy.
        for (int k = 0; k < 31 && sb_q.size() > 0; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            check($sformatf("drain_pop%0d", k), {31'd0, mem_req, mem_addr, mem_data},
                  {31'd0, 1'b1, sb_q[0]});
            void'(sb_q.pop_front());
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("drain_done", {56'd0, count, mem_req, empty}, {56'd0, 6'd0, 1'b0, 1'b1});

        // count==1 in REQ with ack and push in the same cycle.
        drive(0, 1, 16'h0400, 16'h4444, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 16'h0401, 16'h5555, 1, 0, 0);
        check("c1_before", {25'd0, count, mem_req, mem_addr, mem_data},
              {25'd0, 6'd1, 1'b1, 16'h0400, 16'h4444});
        drive(0, 0, 0, 0, 0, 0, 0);
        check("c1_after", {25'd0, count, mem_req, mem_addr, mem_data},
              {25'd0, 6'd1, 1'b1, 16'h0401, 16'h5555});
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("c1_drained", {56'd0, count, mem_req, empty}, {56'd0, 6'd0, 1'b0, 1'b1});

        // Reset mid-transfer with 4 entries; push and ack during reset are ignored.
        for (int k = 0; k < 4; k++) drive(0, 1, 16'h0500 + 16'(k), 16'h6000 + 16'(k), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pre_reset", {57'd0, count, mem_req}, {57'd0, 6'd4, 1'b1});
        drive(1, 1, 16'h0500, 16'h7777, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 16'h0500);
        check("post_reset", {38'd0, count, mem_req, empty, fwd_hit, mem_addr},
              {38'd0, 6'd0, 1'b0, 1'b1, 1'b0, 16'h0000});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_buffer_drain.md
Name: store_buffer_drain

Overview:
- Post-commit store buffer. The retire stage pushes committed stores into the block.
- The block drains them, oldest first, to data memory over a req/ack write handshake.
- It is the reader/drain end of the commit-side store write path.
- It also answers younger loads with store-to-load forwarding from pending entries.

Parameters:
- SB_SIZE, 5, index width; depth = 2**SB_SIZE = 32 entries
- ADDR_W, 16, memory address width
- DATA_W, 16, store data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- push_valid  in  1  commit stage presents a committed store
- push_ready  out  1  buffer can accept; equals !full
- push_addr  in  ADDR_W  store address
- push_data  in  DATA_W  store data
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  head entry address, valid while mem_req
- mem_data  out  DATA_W  head entry data, valid while mem_req
- mem_ack  in  1  memory accepts the write this cycle
- ld_valid  in  1  load forwarding lookup
- ld_addr  in  ADDR_W  load address
- fwd_hit  out  1  a pending store matches ld_addr
- fwd_data  out  DATA_W  data of the youngest matching store
- count  out  SB_SIZE+1  occupied entries
- empty  out  1  count==0
- full  out  1  count==2**SB_SIZE

Behaviour:
- Storage is a circular FIFO with head/tail pointers of SB_SIZE bits that wrap modulo depth. The count register is SB_SIZE+1 bits.
- Push fires when push_valid && push_ready. The entry is written at tail, tail increments, and count+1 is visible the next cycle.
- push_ready is computed from the current count only. When full, a push is refused even if a pop happens the same cycle.
- A push while full is ignored, with no state change.
- The drain FSM has two states, IDLE and REQ.
  - mem_req = (state==REQ).
  - mem_addr and mem_data are driven from the head entry.
- IDLE -> REQ at the edge where count!=0. Minimum latency is push at edge E0, then mem_req high after E1.
- In REQ, the request is held stable until mem_ack. mem_ack arriving the same cycle mem_req rises completes the transfer.
- On mem_ack in REQ:
  - Pop head at the edge; head increments and count decrements.
  - If the post-pop count is nonzero, stay in REQ and present the new head next cycle (back-to-back, one store per cycle).
  - Otherwise go to IDLE.
- mem_ack while IDLE is ignored.
- Simultaneous push and pop: count is unchanged, both pointers advance. Valid in any non-full state, including count==1, where the new entry becomes head.
- Forwarding is combinational.
  - fwd_hit=1 when ld_valid and some occupied entry has addr==ld_addr. The entry currently being requested counts as occupied until popped.
  - fwd_data is the matching entry nearest tail (youngest).
  - A store pushed in the same cycle is not visible to the lookup.
  - fwd_hit=0 when ld_valid=0 or empty. fwd_data is 0 when fwd_hit=0.
- Reset values:
  - head=0, tail=0, count=0, state=IDLE.
  - mem_req=0, push_ready=1, empty=1, full=0, fwd_hit=0.
  - mem_addr, mem_data and fwd_data read 0.
- Reset mid-transfer drops mem_req on the next cycle and discards all entries, including the one in flight. Reset has priority over push and ack.

Test Plan:
- Reset, then push (0x0010,0xAAAA) -> count=1 next cycle; mem_req high one cycle later with addr 0x0010, data 0xAAAA. Hold mem_ack=0 for 3 cycles -> outputs stable. mem_ack=1 -> empty=1 and mem_req=0 next cycle.
- Push 3 stores, then hold mem_ack=1 -> three consecutive write cycles in push order, then IDLE.
- Fill 32 entries -> full=1, push_ready=0. A 33rd push with simultaneous ack -> rejected, count=31 afterward. Continue pushing/draining 40 more -> pointers wrap, data order preserved.
- Push (0x0020,0x1111) then (0x0020,0x2222); ld_addr=0x0020 -> fwd_hit=1, fwd_data=0x2222. After both drained -> fwd_hit=0. A same-cycle push of the load address alone -> fwd_hit=0.
- count==1 in REQ with ack and push same cycle -> count stays 1, mem_req stays high, new entry presented next cycle.
- Assert reset while mem_req=1 with 4 entries -> next cycle mem_req=0, count=0, empty=1.
